sha256_core_mb: RTL
===================

Name: sha256_core_mb

Overview:
Iterative SHA-256/SHA-224 compression core with multi-block chaining and a valid/ready block-input handshake.
- Generalises the single-block core: chaining state persists across blocks; rounds-per-cycle is parametrised; IV is selectable per message.
- Sits between the message padder (supplies 512-bit padded blocks with first/last flags) and the RIPEMD-160 stage of the Hash160 datapath.

Parameters:
ROUNDS_PER_CYCLE, 1, compression rounds evaluated per clock; legal values 1, 2, 4; any other value is an elaboration error.
DIGEST_W, 256, digest port width; fixed at 256. In SHA-224 mode the digest is left-aligned.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
blk_valid  input  1  blk_data/flags valid
blk_ready  output  1  core can accept a block
blk_data  input  512  padded block, word 0 in bits [511:480]
blk_first  input  1  first block of message; load IV before compressing
blk_last  input  1  last block of message; publish digest after compressing
mode_224  input  1  sampled with blk_first; 1 = SHA-224 IV
digest_valid  output  1  one-cycle pulse, digest updated
digest  output  256  final H0..H7; SHA-224 result in [255:32], [31:0] zero
busy  output  1  high in COMPUTE or FINAL

Behaviour:
- Reset values: blk_ready=0 while reset asserted, 1 in the first cycle after release. digest_valid=0, digest=0, busy=0.
  - Internal state after reset: chaining H = SHA-256 IV, mode latch = 0, state = IDLE.
- FSM states and transitions:
  - IDLE: blk_ready=1. On blk_valid&&blk_ready:
    - Capture blk_data into the 16-word W window. Latch blk_last.
    - If blk_first: latch mode_224, and load chaining H and working regs a..h with the IV selected by mode_224. mode_224 is ignored when blk_first=0.
    - Else: load a..h from chaining H.
    - Clear round counter; go to COMPUTE.
  - COMPUTE: each cycle performs ROUNDS_PER_CYCLE rounds.
    - W for rounds 0..15 comes from the window; rounds 16..63 are produced by the sliding window (R new words per cycle).
    - K is indexed combinationally by round counter + i from a constant array; no shifting ROM.
    - After 64/R cycles go to FINAL.
  - FINAL: one cycle; H_i <= H_i + a..h (mod 2^32). Go to IDLE.
    - If latched last=1: digest register <= new H (masked per mode); digest_valid=1 for exactly the following cycle.
- Latency: accepting edge at cycle 0 -> digest_valid high during cycle 64/R+2. Values: R=1 -> 66, R=2 -> 34, R=4 -> 18. The next block is accepted no earlier than that same cycle.
  - Throughput: one block per 64/R+2 cycles.
- blk_ready is 0 in COMPUTE/FINAL; blk_valid in those states is ignored (no capture, no error).
- blk_first=1 and blk_last=1 together is legal (single-block message).
- blk_first=1 arriving mid-message (the previous block had last=0) restarts the message from the IV; the partial message is dropped silently.
- Non-last block: digest and digest_valid are unchanged; the previous digest is held.
- digest holds until the next last-block completion or reset.
- Reset asserted mid-operation: all state returns to reset values immediately; no digest_valid is produced for the aborted block.
- Arithmetic: all additions mod 2^32; no carry kept (no 33-bit registers).

Decomposition:
- Package sha256_pkg:
  - K[0:63] constant array.
  - IV_256 and IV_224 constants.
  - Functions: Sigma0, Sigma1, sigma0, sigma1, ch, maj.
  - FSM state enum.
- One natural sub-module: sha256_round (combinational single round taking a..h, K, W). It is instantiated ROUNDS_PER_CYCLE times in a chain inside a generate loop.

Test Plan:
- SHA-256 "abc" single block, first=last=1, R=1 -> digest_valid during cycle 66, digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (block 80000000 0...0) with R=4 -> digest_valid during cycle 18, digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", R=2, blocks back-to-back:
  - No digest_valid after block 1.
  - After block 2: digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- SHA-224 "abc", mode_224=1 -> digest[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, digest[31:0]=0.
- blk_valid held high while busy -> blk_ready=0 and no second capture. Then assert rst_n=0 at round 30 -> busy=0 and digest=0 with no clock edge. Re-run "abc" -> correct digest.
- Orphaned message: block with first=1,last=0, then "abc" with first=1,last=1 -> exactly one digest_valid, equal to the "abc" digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared types, constants and round helper functions for the SHA-256/SHA-224
// compression core: the 64-entry K table, both initial hash values, the FSM
// state encoding and the six logical functions used by every round.
// -----------------------------------------------------------------------------
package sha256_pkg;

   typedef logic [31:0] word_t;
   // Eight working/chaining words. Index 7 is a/H0 and index 0 is h/H7, so the
   // packed 256-bit view matches the digest layout (H0 in the top bits).
   typedef word_t [7:0] hstate_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_FINAL   = 2'd2;

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam hstate_t IV_256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam hstate_t IV_224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t big_sigma0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// -----------------------------------------------------------------------------
// sha256_round
// One purely combinational SHA-256 compression round.
//   state_i : working variables a..h (a in [7], h in [0])
//   k_i     : round constant
//   w_i     : message schedule word for this round
//   state_o : working variables after the round
// -----------------------------------------------------------------------------
module sha256_round
   import sha256_pkg::*;
(
   input  hstate_t state_i,
   input  word_t   k_i,
   input  word_t   w_i,
   output hstate_t state_o
);

   word_t t1;
   word_t t2;

   assign t1 = state_i[0] + big_sigma1(state_i[3])
             + ch(state_i[3], state_i[2], state_i[1]) + k_i + w_i;
   assign t2 = big_sigma0(state_i[7]) + maj(state_i[7], state_i[6], state_i[5]);

   // New a = t1+t2, new e = d+t1; every other word shifts down one position.
   assign state_o = {t1 + t2, state_i[7], state_i[6], state_i[5],
                     state_i[4] + t1, state_i[3], state_i[2], state_i[1]};

endmodule

// File: rtl/sha256_core_mb.sv
// -----------------------------------------------------------------------------
// sha256_core_mb
// Iterative SHA-256/SHA-224 compression core with multi-block chaining.
// Accepts one 512-bit padded block per valid/ready handshake, runs
// ROUNDS_PER_CYCLE rounds per clock, folds the result into the chaining value
// and publishes the digest after the last block of a message.
//   clk, rst_n     : clock, asynchronous active-low reset
//   blk_valid      : blk_data/flags valid
//   blk_ready      : core idle and able to accept a block
//   blk_data       : padded block, word 0 in [511:480]
//   blk_first      : first block of a message (reload IV)
//   blk_last       : last block of a message (publish digest)
//   mode_224       : sampled with blk_first; 1 selects the SHA-224 IV
//   digest_valid   : one-cycle pulse when digest is updated
//   digest         : H0..H7; SHA-224 result left-aligned, [31:0] zero
//   busy           : high while compressing or finalising
// -----------------------------------------------------------------------------
module sha256_core_mb
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int DIGEST_W         = 256
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                blk_valid,
   output logic                blk_ready,
   input  logic [511:0]        blk_data,
   input  logic                blk_first,
   input  logic                blk_last,
   input  logic                mode_224,
   output logic                digest_valid,
   output logic [DIGEST_W-1:0] digest,
   output logic                busy
);

   localparam int         R        = ROUNDS_PER_CYCLE;
   localparam logic [5:0] RND_STEP = 6'(R);
   localparam logic [5:0] LAST_RND = 6'(64 - R);

   if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
      $error("sha256_core_mb: ROUNDS_PER_CYCLE must be 1, 2 or 4");
   end
   if (DIGEST_W != 256) begin : g_bad_digest_w
      $error("sha256_core_mb: DIGEST_W must be 256");
   end

   logic [1:0]   state_q, state_d;
   logic [5:0]   rnd_q, rnd_d;
   word_t        w_q [16];
   word_t        w_d [16];
   hstate_t      work_q, work_d;
   hstate_t      h_q, h_d;
   logic         mode_q, mode_d;
   logic         last_q, last_d;
   logic [255:0] digest_q, digest_d;
   logic         dv_q, dv_d;

   // ---------------------------------------------------------------------------
   // Message schedule: the window holds W[t..t+15] with the current round's word
   // at index 0. R new words are appended per cycle; a later new word may depend
   // on an earlier one from the same cycle, hence the in-order loop.
   // ---------------------------------------------------------------------------
   word_t ext [16+R];

   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = w_q[i];
      for (int j = 0; j < R; j++) begin
         ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j]
                   + small_sigma0(ext[1+j]) + ext[j];
      end
   end

   // ---------------------------------------------------------------------------
   // Round chain: R rounds back to back, each with its K looked up directly
   // from the round counter.
   // ---------------------------------------------------------------------------
   hstate_t chain [R+1];

   assign chain[0] = work_q;

   for (genvar gi = 0; gi < R; gi++) begin : g_round
      sha256_round u_round (
         .state_i (chain[gi]),
         .k_i     (K[rnd_q + 6'(gi)]),
         .w_i     (w_q[gi]),
         .state_o (chain[gi+1])
      );
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   hstate_t iv_sel;
   hstate_t h_sum;

   always_comb begin
      // NOTE: every variable gets its hold/default value before the case so no
      // path leaves one unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      rnd_d    = rnd_q;
      w_d      = w_q;
      work_d   = work_q;
      h_d      = h_q;
      mode_d   = mode_q;
      last_d   = last_q;
      digest_d = digest_q;
      dv_d     = 1'b0;

      iv_sel = mode_224 ? IV_224 : IV_256;
      for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + work_q[i];

      case (state_q)
         ST_IDLE: begin
            if (blk_valid) begin
               for (int i = 0; i < 16; i++) w_d[i] = blk_data[511-32*i -: 32];
               last_d = blk_last;
               // A first block always restarts from the IV, silently dropping
               // any message left unfinished.
               if (blk_first) begin
                  mode_d = mode_224;
                  h_d    = iv_sel;
                  work_d = iv_sel;
               end else begin
                  work_d = h_q;
               end
               rnd_d   = '0;
               state_d = ST_COMPUTE;
            end
         end

         ST_COMPUTE: begin
            work_d = chain[R];
            for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
            rnd_d = rnd_q + RND_STEP;
            if (rnd_q == LAST_RND) state_d = ST_FINAL;
         end

         ST_FINAL: begin
            h_d = h_sum;
            if (last_q) begin
               dv_d     = 1'b1;
               digest_d = mode_q ? {h_sum[7:1], 32'h0} : h_sum;
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rnd_q    <= '0;
         work_q   <= '0;
         h_q      <= IV_256;
         mode_q   <= 1'b0;
         last_q   <= 1'b0;
         digest_q <= '0;
         dv_q     <= 1'b0;
         // NOTE: the schedule window is reset as well; it is only 16 words and
         // an aborted block must leave no trace behind.
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together from
         // the pre-edge values.
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         work_q   <= work_d;
         h_q      <= h_d;
         mode_q   <= mode_d;
         last_q   <= last_d;
         digest_q <= digest_d;
         dv_q     <= dv_d;
         for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      end
   end

   // Ready is forced low while reset is held even though the FSM already sits
   // in IDLE, and rises as soon as reset is released.
   assign blk_ready    = rst_n && (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign digest_valid = dv_q;
   assign digest       = digest_q;

endmodule
